urv_irq_ctrl: RTL and testbench

External interrupt aggregator feeding the uRV core's single external-interrupt request (`exp_irq_i` of the exceptions unit). It synchronises up to 32 asynchronous interrupt lines, detects edges or samples levels per line, latches pending state, applies an enable mask and drives one registered request level to the core. Software services it through a small register bus: it enables sources, selects modes, claims the highest-priority source and clears pending bits.

---
 rtl/urv_irq_ctrl_pkg.sv | 14 +
 rtl/urv_irq_ctrl_if.sv | 21 ++
 rtl/urv_irq_sync.sv | 28 ++
 rtl/urv_irq_ctrl.sv | 100 ++++++++++
 tb/tb_urv_irq_ctrl.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/urv_irq_ctrl_pkg.sv
// Shared constants for the uRV external interrupt aggregator.
// Register word offsets on the 2-bit software bus.
package urv_irq_ctrl_pkg;

    localparam int IRQC_MAX_IRQS = 32;

    typedef enum logic [1:0] {
        IRQC_REG_ENABLE  = 2'd0,
        IRQC_REG_MODE    = 2'd1,
        IRQC_REG_PENDING = 2'd2,
        IRQC_REG_CLAIM   = 2'd3
    } irqc_reg_e;

endpackage

// File: rtl/urv_irq_ctrl_if.sv
// Register bus between software (master) and the interrupt aggregator (slave).
// Handshake: a single-cycle bus_rd_i or bus_wr_i strobe in cycle T is answered by
// bus_ack_o=1 for exactly one cycle at T+1, with read data valid only while ack is high.
interface urv_irq_ctrl_if;
    logic [1:0]  bus_addr_i;
    logic        bus_wr_i;
    logic        bus_rd_i;
    logic [31:0] bus_data_i;
    logic [31:0] bus_data_o;
    logic        bus_ack_o;

    modport master (
        output bus_addr_i, bus_wr_i, bus_rd_i, bus_data_i,
        input  bus_data_o, bus_ack_o
    );

    modport slave (
        input  bus_addr_i, bus_wr_i, bus_rd_i, bus_data_i,
        output bus_data_o, bus_ack_o
    );
endinterface

// File: rtl/urv_irq_sync.sv
// Two-flop synchroniser for one asynchronous interrupt line, plus a delay flop
// so the synchronised value can be edge-detected.
module urv_irq_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o
);
    logic meta_q;
    logic sync_q;
    logic dly_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            dly_q  <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            dly_q  <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~dly_q;
endmodule

// File: rtl/urv_irq_ctrl.sv
// External interrupt aggregator: per-line edge/level pending state, enable mask,
// priority claim and a single registered request to the core.
module urv_irq_ctrl
    import urv_irq_ctrl_pkg::*;
#(
    parameter int G_NUM_IRQS = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [G_NUM_IRQS-1:0] irq_i,
    urv_irq_ctrl_if.slave         bus,
    output logic                  irq_o
);
    localparam int N = G_NUM_IRQS;

    logic [N-1:0] s, rise;
    logic [N-1:0] enable_q, enable_d;
    logic [N-1:0] mode_q, mode_d;
    logic [N-1:0] pending_q, pending_d;
    logic [N-1:0] active, clr;
    logic [31:0]  data_q, data_d;
    logic         ack_q, irq_q;
    logic         do_wr, do_rd;
    logic [5:0]   claim;
    logic         unused_data;

    // Lowest index wins, so scan downwards and let later hits overwrite.
    function automatic logic [5:0] claim_id(input logic [N-1:0] act);
        claim_id = 6'd0;
        for (int i = N - 1; i >= 0; i--) begin
            if (act[i]) claim_id = 6'(i + 1);
        end
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_sync
        urv_irq_sync u_sync (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .async_i(irq_i[g]),
            .sync_o (s[g]),
            .rise_o (rise[g])
        );
    end

    assign unused_data = ^bus.bus_data_i;

    always_comb begin
        do_wr     = bus.bus_wr_i;
        do_rd     = bus.bus_rd_i & ~bus.bus_wr_i;
        active    = pending_q & enable_q;
        claim     = claim_id(active);
        enable_d  = enable_q;
        mode_d    = mode_q;
        clr       = '0;
        data_d    = 32'd0;
        if (do_wr) begin
            case (bus.bus_addr_i)
                IRQC_REG_ENABLE:  enable_d = bus.bus_data_i[N-1:0];
                IRQC_REG_MODE:    mode_d   = bus.bus_data_i[N-1:0];
                IRQC_REG_PENDING: clr      = bus.bus_data_i[N-1:0];
                default:          ;
            endcase
        end
        if (do_rd) begin
            case (bus.bus_addr_i)
                IRQC_REG_ENABLE:  data_d = 32'(enable_q);
                IRQC_REG_MODE:    data_d = 32'(mode_q);
                IRQC_REG_PENDING: data_d = 32'(pending_q);
                default: begin
                    data_d = 32'(claim);
                    if (claim != 6'd0) clr = N'(1) << (claim - 6'd1);
                end
            endcase
        end
        // Edge bits latch with set-over-clear; level bits just follow the line.
        pending_d = (mode_q & ((pending_q & ~clr) | rise)) | (~mode_q & s);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            enable_q  <= '0;
            mode_q    <= '0;
            pending_q <= '0;
            data_q    <= 32'd0;
            ack_q     <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            enable_q  <= enable_d;
            mode_q    <= mode_d;
            pending_q <= pending_d;
            data_q    <= data_d;
            ack_q     <= bus.bus_rd_i | bus.bus_wr_i;
            irq_q     <= |active;
        end
    end

    assign bus.bus_data_o = data_q;
    assign bus.bus_ack_o  = ack_q;
    assign irq_o          = irq_q;
endmodule

// File: tb/tb_urv_irq_ctrl.sv
// Directed bench for urv_irq_ctrl: an 8-line instance for the main behaviour and
// a 4-line instance for register width masking and mid-pulse reset.
module tb_urv_irq_ctrl;
    import urv_irq_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] irq8;
    logic [3:0] irq4;
    logic       irq_o8, irq_o4;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    urv_irq_ctrl_if bus8 ();
    urv_irq_ctrl_if bus4 ();

    urv_irq_ctrl #(.G_NUM_IRQS(8)) u_dut8 (
        .clk_i(clk), .rst_i(rst), .irq_i(irq8), .bus(bus8), .irq_o(irq_o8)
    );

    urv_irq_ctrl #(.G_NUM_IRQS(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .irq_i(irq4), .bus(bus4), .irq_o(irq_o4)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_drive(input bit sel, input logic [1:0] addr, input bit rd, input bit wr,
                             input logic [31:0] data);
        if (sel) begin
            bus4.bus_addr_i = addr; bus4.bus_rd_i = rd; bus4.bus_wr_i = wr; bus4.bus_data_i = data;
        end else begin
            bus8.bus_addr_i = addr; bus8.bus_rd_i = rd; bus8.bus_wr_i = wr; bus8.bus_data_i = data;
        end
    endtask

    function automatic logic ack_of(input bit sel);
        return sel ? bus4.bus_ack_o : bus8.bus_ack_o;
    endfunction

    function automatic logic [31:0] data_of(input bit sel);
        return sel ? bus4.bus_data_o : bus8.bus_data_o;
    endfunction

    task automatic bus_write(input bit sel, input logic [1:0] addr, input logic [31:0] data);
        bus_drive(sel, addr, 1'b0, 1'b1, data);
        tick(1);
        bus_drive(sel, 2'd0, 1'b0, 1'b0, 32'd0);
        check("wr_ack", 32'(ack_of(sel)), 32'd1);
    endtask

    task automatic bus_read(input bit sel, input logic [1:0] addr, input string tag,
                            input logic [31:0] exp);
        bus_drive(sel, addr, 1'b1, 1'b0, 32'd0);
        tick(1);
        bus_drive(sel, 2'd0, 1'b0, 1'b0, 32'd0);
        check({tag, "_ack"}, 32'(ack_of(sel)), 32'd1);
        check(tag, data_of(sel), exp);
    endtask

    initial begin
        rst  = 1'b1;
        irq8 = '0;
        irq4 = '0;
        bus_drive(1'b0, 2'd0, 1'b0, 1'b0, 32'd0);
        bus_drive(1'b1, 2'd0, 1'b0, 1'b0, 32'd0);
        tick(3);
        rst = 1'b0;

        // Reset, then idle
        check("rst_ack", 32'(bus8.bus_ack_o), 32'd0);
        check("rst_data", bus8.bus_data_o, 32'd0);
        check("rst_irq", 32'(irq_o8), 32'd0);
        bus_read(1'b0, IRQC_REG_ENABLE, "rst_enable", 32'd0);
        bus_read(1'b0, IRQC_REG_MODE, "rst_mode", 32'd0);
        bus_read(1'b0, IRQC_REG_PENDING, "rst_pending", 32'd0);
        bus_read(1'b0, IRQC_REG_CLAIM, "rst_claim", 32'd0);
        tick(1);
        check("ack_one_cycle", 32'(bus8.bus_ack_o), 32'd0);

        // Edge latch on line 2
        bus_write(1'b0, IRQC_REG_MODE, 32'hFF);
        bus_write(1'b0, IRQC_REG_ENABLE, 32'h04);
        irq8[2] = 1'b1;
        tick(3);
        irq8[2] = 1'b0;
        check("edge_irq_k3", 32'(irq_o8), 32'd0);
        tick(1);
        check("edge_irq_k4", 32'(irq_o8), 32'd1);
        bus_read(1'b0, IRQC_REG_PENDING, "edge_pending", 32'h04);
        bus_read(1'b0, IRQC_REG_CLAIM, "edge_claim", 32'd3);
        check("claim_irq_t1", 32'(irq_o8), 32'd1);
        tick(1);
        check("claim_irq_t2", 32'(irq_o8), 32'd0);
        bus_read(1'b0, IRQC_REG_PENDING, "edge_pending_clr", 32'h00);

        // Priority: simultaneous edges on lines 5 and 1
        bus_write(1'b0, IRQC_REG_ENABLE, 32'hFF);
        irq8 = 8'h22;
        tick(3);
        irq8 = 8'h00;
        tick(2);
        check("prio_irq", 32'(irq_o8), 32'd1);
        exp_q = {32'd2, 32'd6, 32'd0};
        while (exp_q.size() > 0) bus_read(1'b0, IRQC_REG_CLAIM, "prio_claim", exp_q.pop_front());

        // Level mode on line 0
        bus_write(1'b0, IRQC_REG_MODE, 32'h00);
        bus_write(1'b0, IRQC_REG_ENABLE, 32'h01);
        irq8[0] = 1'b1;
        tick(4);
        check("level_irq_hi", 32'(irq_o8), 32'd1);
        bus_write(1'b0, IRQC_REG_PENDING, 32'h01);
        bus_read(1'b0, IRQC_REG_PENDING, "level_w1c", 32'h01);
        bus_read(1'b0, IRQC_REG_CLAIM, "level_claim", 32'd1);
        bus_read(1'b0, IRQC_REG_PENDING, "level_after_claim", 32'h01);
        irq8[0] = 1'b0;
        tick(3);
        check("level_fall_k3", 32'(irq_o8), 32'd1);
        tick(1);
        check("level_fall_k4", 32'(irq_o8), 32'd0);

        // Set/clear collision on line 3: W1C sampled on the same edge that sets pending
        bus_write(1'b0, IRQC_REG_MODE, 32'hFF);
        bus_write(1'b0, IRQC_REG_ENABLE, 32'h08);
        irq8[3] = 1'b1;
        tick(2);
        bus_write(1'b0, IRQC_REG_PENDING, 32'h08);
        tick(1);
        check("collide_irq", 32'(irq_o8), 32'd1);
        bus_read(1'b0, IRQC_REG_PENDING, "collide_pending", 32'h08);
        check("collide_irq_hold", 32'(irq_o8), 32'd1);
        bus_read(1'b0, IRQC_REG_CLAIM, "collide_claim", 32'd4);
        irq8[3] = 1'b0;

        // Read and write strobed together: write happens, data is 0
        bus_drive(1'b0, IRQC_REG_ENABLE, 1'b1, 1'b1, 32'h5A);
        tick(1);
        bus_drive(1'b0, 2'd0, 1'b0, 1'b0, 32'd0);
        check("rdwr_ack", 32'(bus8.bus_ack_o), 32'd1);
        check("rdwr_data", bus8.bus_data_o, 32'd0);
        bus_read(1'b0, IRQC_REG_ENABLE, "rdwr_enable", 32'h5A);

        // Width masking and masked pending on the 4-line instance
        bus_write(1'b1, IRQC_REG_ENABLE, 32'hFFFF_FFFF);
        bus_read(1'b1, IRQC_REG_ENABLE, "w4_enable", 32'h0000_000F);
        bus_write(1'b1, IRQC_REG_MODE, 32'hFFFF_FFFF);
        bus_read(1'b1, IRQC_REG_MODE, "w4_mode", 32'h0000_000F);
        bus_write(1'b1, IRQC_REG_ENABLE, 32'h0000_0000);
        irq4 = 4'h2;
        tick(3);
        irq4 = 4'h0;
        tick(2);
        bus_read(1'b1, IRQC_REG_PENDING, "w4_pending", 32'h2);
        check("w4_masked_irq", 32'(irq_o4), 32'd0);
        bus_read(1'b1, IRQC_REG_CLAIM, "w4_claim_none", 32'd0);

        // Reset mid-pulse with a read strobe in flight
        bus_write(1'b1, IRQC_REG_ENABLE, 32'hF);
        irq4 = 4'h4;
        tick(4);
        check("w4_pre_rst_irq", 32'(irq_o4), 32'd1);
        rst = 1'b1;
        bus_drive(1'b1, IRQC_REG_CLAIM, 1'b1, 1'b0, 32'd0);
        tick(1);
        rst  = 1'b0;
        irq4 = 4'h0;
        bus_drive(1'b1, 2'd0, 1'b0, 1'b0, 32'd0);
        check("w4_rst_ack", 32'(bus4.bus_ack_o), 32'd0);
        check("w4_rst_data", bus4.bus_data_o, 32'd0);
        check("w4_rst_irq", 32'(irq_o4), 32'd0);
        bus_read(1'b1, IRQC_REG_PENDING, "w4_rst_pending", 32'd0);
        bus_read(1'b1, IRQC_REG_ENABLE, "w4_rst_enable", 32'd0);
        bus_read(1'b1, IRQC_REG_MODE, "w4_rst_mode", 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
